prog_timer: RTL
===============

PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter WIDTH, default 16: bit width of count, value and internal counter.
REQ-002 Parameter PS_WIDTH, default 8: prescaler width; used only when PROG_TIMER_PRESCALE_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces the reset state of REQ-020 immediately.
REQ-005 start  input  1  single-cycle arm/restart request.
REQ-006 stop  input  1  single-cycle abort request.
REQ-007 mode  input  1  0 = periodic, 1 = one-shot; sampled on accepted start.
REQ-008 count  input  WIDTH  terminal value; period = count+1 advances.
REQ-009 prescale  input  PS_WIDTH  advance divider (present only with PROG_TIMER_PRESCALE_EN); advance every prescale+1 cycles.
REQ-010 tick  output  1  registered one-cycle pulse per terminal count.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  sticky one-shot completion flag.
REQ-013 value  output  WIDTH  current counter value.

Function
REQ-014 FSM states IDLE, RUN, HOLD; transitions only as stated here.
REQ-015 start accepted in any state: latches count into count_q and mode into mode_q, clears value to 0, clears done, enters RUN next cycle.
REQ-016 In RUN, on each advance: value==count_q -> tick=1 next cycle, value<=0; otherwise value<=value+1 (WIDTH-bit, no saturation needed).
REQ-017 Periodic mode: at each terminal count, count_q reloads from count input; FSM stays RUN; new period takes effect from the next period.
REQ-018 One-shot mode: at terminal count, tick pulses once, done<=1, FSM -> HOLD; value holds 0; no further ticks until next start.
REQ-019 count=0: tick asserted on every advance (every cycle without prescaler) while RUN.
REQ-020 stop in RUN or HOLD -> IDLE next cycle, value<=0, no tick generated that cycle even at terminal count, done unchanged.
REQ-021 start and stop in same cycle: stop wins; FSM -> IDLE.
REQ-022 start while RUN: restart per REQ-015; a pending terminal-count tick that cycle is suppressed.
REQ-023 Without prescaler an advance occurs every RUN cycle; first tick after start occurs count+2 cycles after the start edge (1 cycle arm, count+1 advances).
REQ-024 busy=1 exactly when state==RUN; tick width is always one clk cycle.

Reset
REQ-025 On reset: state IDLE, tick=0, busy=0, done=0, value=0, count_q=0, mode_q=0, prescaler counter=0.
REQ-026 Reset asserted mid-RUN aborts immediately with no tick; after release, block stays IDLE until start.

Configuration
REQ-027 Macro PROG_TIMER_PRESCALE_EN defined: prescale port and PS_WIDTH-bit prescaler exist; prescale latched on start; advance strobed once per prescale+1 RUN cycles; prescaler cleared on start, stop, reset.
REQ-028 Macro PROG_TIMER_PRESCALE_EN undefined: no prescale port, no prescaler logic; advance every RUN cycle.

Verification
REQ-029 WIDTH=16, mode=0, count=3, start pulse -> first tick 5 cycles after start edge, then a tick every 4 cycles; busy=1 throughout.
REQ-030 mode=1, count=5, start -> exactly one tick, done=1 same cycle as tick, busy=0, state HOLD; no tick over next 20 cycles.
REQ-031 Periodic count=3 running, change count to 7 mid-period -> current period remains 4 cycles, subsequent periods 8 cycles.
REQ-032 count=2 running, assert start and stop together at value==2 -> no tick, busy=0 next cycle, value=0.
REQ-033 Reset asserted asynchronously mid-RUN (value=9, count=20) -> outputs zero without clock edge; no tick after release.
REQ-034 With PROG_TIMER_PRESCALE_EN, prescale=2, count=1, mode=0 -> tick period 6 cycles; without macro, same count -> period 2 cycles.

Source files
------------

// File: rtl/prog_timer_if.sv
// prog_timer control/status bundle; the prescale field exists only
// when PROG_TIMER_PRESCALE_EN is defined.
interface prog_timer_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PS_WIDTH = 8
) ();
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] value;
`ifdef PROG_TIMER_PRESCALE_EN
  logic [PS_WIDTH-1:0] prescale;

  modport master (
    output start, stop, mode, count, prescale,
    input  tick, busy, done, value
  );
  modport slave (
    input  start, stop, mode, count, prescale,
    output tick, busy, done, value
  );
`else
  localparam int unsigned unused_ps_w = PS_WIDTH;

  modport master (
    output start, stop, mode, count,
    input  tick, busy, done, value
  );
  modport slave (
    input  start, stop, mode, count,
    output tick, busy, done, value
  );
`endif
endinterface

// File: rtl/prog_timer.sv
// Programmable periodic/one-shot timer with IDLE/RUN/HOLD FSM.
// Optional advance prescaler enabled by PROG_TIMER_PRESCALE_EN.
module prog_timer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PS_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  prog_timer_if.slave tif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             armed_q, armed_d;
  logic             adv;

`ifdef PROG_TIMER_PRESCALE_EN
  logic [PS_WIDTH-1:0] ps_q, ps_d;
  logic [PS_WIDTH-1:0] psl_q, psl_d;
`else
  localparam int unsigned unused_ps_w = PS_WIDTH;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      armed_q <= 1'b0;
`ifdef PROG_TIMER_PRESCALE_EN
      ps_q    <= '0;
      psl_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      armed_q <= armed_d;
`ifdef PROG_TIMER_PRESCALE_EN
      ps_q    <= ps_d;
      psl_q   <= psl_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    mode_d  = mode_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    armed_d = armed_q;
`ifdef PROG_TIMER_PRESCALE_EN
    psl_d   = psl_q;
    adv     = armed_q && (ps_q == psl_q);
    ps_d    = '0;
    if (armed_q && !adv) begin
      ps_d = ps_q + PS_WIDTH'(1);
    end
`else
    adv     = armed_q;
`endif

    // stop beats start; both drop any terminal tick this cycle
    if (tif.stop) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
      end
      value_d = '0;
      armed_d = 1'b0;
`ifdef PROG_TIMER_PRESCALE_EN
      ps_d    = '0;
`endif
    end else if (tif.start) begin
      state_d = RUN;
      value_d = '0;
      count_d = tif.count;
      mode_d  = tif.mode;
      done_d  = 1'b0;
      armed_d = 1'b0;
`ifdef PROG_TIMER_PRESCALE_EN
      ps_d    = '0;
      psl_d   = tif.prescale;
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          // first RUN cycle only arms; advances follow
          if (!armed_q) begin
            armed_d = 1'b1;
          end else if (adv) begin
            if (value_q == count_q) begin
              tick_d  = 1'b1;
              value_d = '0;
              if (mode_q) begin
                done_d  = 1'b1;
                state_d = HOLD;
                armed_d = 1'b0;
              end else begin
                count_d = tif.count;
              end
            end else begin
              value_d = value_q + WIDTH'(1);
            end
          end
        end
        HOLD: value_d = '0;
        default: ;
      endcase
    end
  end

  assign tif.tick  = tick_q;
  assign tif.busy  = (state_q == RUN);
  assign tif.done  = done_q;
  assign tif.value = value_q;

endmodule
